// File: rtl/packet_injector_if.sv
// packet_injector_if: descriptor and payload handshakes plus the phit output.
// slave = injector side, master = traffic source / network sink side.
interface packet_injector_if;
    logic       i_desc_valid;
    logic       o_desc_ready;
    logic [5:0] i_route;
    logic [3:0] i_len;
    logic       i_pl_valid;
    logic       o_pl_ready;
    logic [5:0] i_pl_data;
    logic [7:0] o_phit;
    logic       o_busy;

    modport slave (
        input  i_desc_valid, i_route, i_len,
        input  i_pl_valid, i_pl_data,
        output o_desc_ready, o_pl_ready, o_phit, o_busy
    );

    modport master (
        output i_desc_valid, i_route, i_len,
        output i_pl_valid, i_pl_data,
        input  o_desc_ready, o_pl_ready, o_phit, o_busy
    );
endinterface

// File: rtl/packet_injector.sv
// packet_injector: buffers a whole packet, then emits HEAD + contiguous
// PAYLOAD phits followed by IDLE_GAP idle phits.
// Ports: i_clk, i_rst (async, active-high), bus (packet_injector_if.slave):
//   descriptor valid/ready + route/len, payload valid/ready + data,
//   o_phit (registered), o_busy.
// Option: define INJECTOR_PARITY_EN to append an XOR parity phit.
module packet_injector #(
    parameter int unsigned IDLE_GAP = 1
) (
    input logic              i_clk,
    input logic              i_rst,
    packet_injector_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_HEAD, S_PAYLOAD, S_GAP
    } state_t;

    state_t     state_q, state_d, after_pkt;
    logic [5:0] route_q, route_d;
    logic [3:0] len_q, len_d;
    logic [3:0] wr_q, wr_d;
    logic [3:0] rd_q, rd_d;
    logic [3:0] last_rd;
    logic [2:0] gap_q, gap_d;
    logic [7:0] phit_q, phit_d;
    logic       rdy_q;
    logic [5:0] mem [15];
    logic [5:0] pay_word;
    logic       desc_fire, pl_fire, has_pay;

`ifdef INJECTOR_PARITY_EN
    logic [5:0] par_q, par_d;
    // The parity phit is always sent, so rd runs one past the data.
    assign has_pay = 1'b1;
    assign last_rd = len_q;
`else
    assign has_pay = (len_q != 4'd0);
    assign last_rd = len_q - 4'd1;
`endif

    assign after_pkt = (IDLE_GAP == 0) ? S_IDLE : S_GAP;

    // rdy_q holds desc_ready low until the first edge after reset.
    assign bus.o_desc_ready = (state_q == S_IDLE) && rdy_q;
    assign bus.o_pl_ready   = (state_q == S_LOAD);
    assign bus.o_busy       = (state_q != S_IDLE);
    assign bus.o_phit       = phit_q;

    assign desc_fire = bus.i_desc_valid && bus.o_desc_ready;
    assign pl_fire   = bus.i_pl_valid && bus.o_pl_ready;

    always_comb begin
        state_d = state_q;
        route_d = route_q;
        len_d   = len_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        gap_d   = gap_q;
`ifdef INJECTOR_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (desc_fire) begin
                    route_d = bus.i_route;
                    len_d   = bus.i_len;
                    wr_d    = 4'd0;
                    rd_d    = 4'd0;
`ifdef INJECTOR_PARITY_EN
                    par_d   = 6'h00;
`endif
                    state_d = (bus.i_len == 4'd0) ? S_HEAD : S_LOAD;
                end
            end
            S_LOAD: begin
                if (pl_fire) begin
                    wr_d = wr_q + 4'd1;
`ifdef INJECTOR_PARITY_EN
                    par_d = par_q ^ bus.i_pl_data;
`endif
                    if (wr_q == len_q - 4'd1) state_d = S_HEAD;
                end
            end
            S_HEAD: begin
                rd_d  = 4'd0;
                gap_d = 3'd0;
                state_d = has_pay ? S_PAYLOAD : after_pkt;
            end
            S_PAYLOAD: begin
                gap_d = 3'd0;
                if (rd_q == last_rd) state_d = after_pkt;
                else rd_d = rd_q + 4'd1;
            end
            S_GAP: begin
                if (gap_q == 3'(IDLE_GAP - 1)) state_d = S_IDLE;
                else gap_d = gap_q + 3'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The phit is computed for the state being entered and registered,
    // so it lines up with the state and never depends on inputs late.
    always_comb begin
`ifdef INJECTOR_PARITY_EN
        if (rd_d == len_d) pay_word = par_d;
        else pay_word = mem[rd_d];
`else
        pay_word = mem[rd_d];
`endif
    end

    always_comb begin
        phit_d = 8'h00;
        unique case (state_d)
            S_HEAD:    phit_d = {2'b11, route_d};
            S_PAYLOAD: phit_d = {2'b10, pay_word};
            default:   phit_d = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            route_q <= 6'h00;
            len_q   <= 4'd0;
            wr_q    <= 4'd0;
            rd_q    <= 4'd0;
            gap_q   <= 3'd0;
            phit_q  <= 8'h00;
            rdy_q   <= 1'b0;
`ifdef INJECTOR_PARITY_EN
            par_q   <= 6'h00;
`endif
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            len_q   <= len_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            gap_q   <= gap_d;
            phit_q  <= phit_d;
            rdy_q   <= 1'b1;
`ifdef INJECTOR_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Packet buffer; contents after reset are irrelevant.
    always_ff @(posedge i_clk) begin
        if (pl_fire) mem[wr_q] <= bus.i_pl_data;
    end
endmodule
